// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared defaults and FIFO state encoding for the stream demux
package stream_pkg;

    localparam int WIDTH_DEFAULT = 8;
    localparam int CNT_W_DEFAULT = 8;
    localparam int DEMUX_DEPTH   = 2;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } fifo_state_t;

    function automatic int occupancy(input fifo_state_t s);
        return int'(s);
    endfunction

endpackage

// File: rtl/demux_fifo.sv
// rtl/demux_fifo.sv - 2-entry output FIFO with delivered-word counter
module demux_fifo
    import stream_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             valid,
    input  logic             ready,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    fifo_state_t      state;
    logic [WIDTH-1:0] tail;
    logic             do_push;
    logic             do_pop;

    assign full    = (occupancy(state) == DEMUX_DEPTH);
    assign valid   = (state != ST_EMPTY);
    assign do_push = push && !full;
    assign do_pop  = valid && ready;

    // The head is its own register so data holds its last value once the FIFO drains.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_EMPTY;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_pop) begin
                count <= count + CNT_W'(1);
            end
            case (state)
                ST_EMPTY: begin
                    if (do_push) begin
                        head  <= push_data;
                        state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (do_push && do_pop) begin
                        head <= push_data;
                    end else if (do_push) begin
                        tail  <= push_data;
                        state <= ST_FULL;
                    end else if (do_pop) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (do_pop) begin
                        head  <= tail;
                        state <= ST_ONE;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - 1-to-2 stream demultiplexer with per-output 2-entry FIFOs
module stream_demux
    import stream_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic [CNT_W-1:0] out0_count,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [CNT_W-1:0] out1_count
);

    logic full0;
    logic full1;
    logic push0;
    logic push1;

    // Ready looks only at registered FIFO state, never at the consumers' ready.
    assign in_ready = !reset && !(in_sel ? full1 : full0);
    assign push0    = in_valid && in_ready && !in_sel;
    assign push1    = in_valid && in_ready && in_sel;

    demux_fifo #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_fifo0 (
        .clock     (clock),
        .reset     (reset),
        .push      (push0),
        .push_data (in_data),
        .full      (full0),
        .valid     (out0_valid),
        .ready     (out0_ready),
        .head      (out0_data),
        .count     (out0_count)
    );

    demux_fifo #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_fifo1 (
        .clock     (clock),
        .reset     (reset),
        .push      (push1),
        .push_data (in_data),
        .full      (full1),
        .valid     (out1_valid),
        .ready     (out1_ready),
        .head      (out1_data),
        .count     (out1_count)
    );

endmodule

// File: tb/tb_stream_demux.sv
// tb/tb_stream_demux.sv - scoreboard bench for stream_demux
module tb_stream_demux;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_sel = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             out0_valid;
    logic             out0_ready = 1'b0;
    logic [WIDTH-1:0] out0_data;
    logic [CNT_W-1:0] out0_count;
    logic             out1_valid;
    logic             out1_ready = 1'b0;
    logic [WIDTH-1:0] out1_data;
    logic [CNT_W-1:0] out1_count;

    always #5 clock = ~clock;

    stream_demux #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out0_count (out0_count),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .out1_count (out1_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    logic [WIDTH-1:0] last0 = '0;
    logic [WIDTH-1:0] last1 = '0;
    int cnt0 = 0;
    int cnt1 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs with the queue model, then retires words the consumers take.
    always @(negedge clock) begin : monitor
        logic exp_ready;
        if (q0.size() != 0) last0 = q0[0];
        if (q1.size() != 0) last1 = q1[0];
        exp_ready = !reset && ((in_sel ? q1.size() : q0.size()) < 2);
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        chk("out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
        chk("out0_data", 32'(out0_data), 32'(last0));
        chk("out0_count", 32'(out0_count), cnt0 % (1 << CNT_W));
        chk("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
        chk("out1_data", 32'(out1_data), 32'(last1));
        chk("out1_count", 32'(out1_count), cnt1 % (1 << CNT_W));
        if (reset) begin
            q0.delete();
            q1.delete();
            cnt0 = 0;
            cnt1 = 0;
            last0 = '0;
            last1 = '0;
        end else begin
            if (q0.size() != 0 && out0_ready) begin
                void'(q0.pop_front());
                cnt0++;
            end
            if (q1.size() != 0 && out1_ready) begin
                void'(q1.pop_front());
                cnt1++;
            end
        end
    end

    // One clock of stimulus; an accepted word is pushed to the model after the monitor has run.
    task automatic cyc(input bit v, input bit s, input logic [WIDTH-1:0] d,
                       input bit r0, input bit r1, input bit rst);
        @(posedge clock);
        #1;
        in_valid   = v;
        in_sel     = s;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
        reset      = rst;
        @(negedge clock);
        #2;
        if (in_valid && in_ready && !reset) begin
            if (in_sel) q1.push_back(in_data);
            else        q0.push_back(in_data);
        end
    endtask

    task automatic send(input bit s, input logic [WIDTH-1:0] d, input bit r0, input bit r1);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            cyc(1'b1, s, d, r0, r1, 1'b0);
            ok = in_ready;
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL send_timeout: word %0h sel %0d not accepted within 20 cycles", d, s);
        end
    endtask

    task automatic idle(input int n, input bit r0, input bit r1);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, r0, r1, 1'b0);
    endtask

    task automatic rand_run(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), WIDTH'($urandom),
                $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1'b0);
        end
    endtask

    initial begin
        // reset held with a live producer
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'h5A, 1'b1, 1'b1, 1'b1);
        idle(1, 1'b1, 1'b1);

        // routing
        send(1'b0, 8'h11, 1'b1, 1'b1);
        send(1'b1, 8'h22, 1'b1, 1'b1);
        idle(3, 1'b1, 1'b1);
        chk("route_count0", 32'(out0_count), 32'd1);
        chk("route_count1", 32'(out1_count), 32'd1);

        // backpressure on out0 while out1 stays free
        send(1'b0, 8'hA0, 1'b0, 1'b1);
        send(1'b0, 8'hA1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 8'hA2, 1'b0, 1'b1, 1'b0);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        send(1'b1, 8'hB0, 1'b0, 1'b1);
        send(1'b0, 8'hA2, 1'b1, 1'b1);
        idle(4, 1'b1, 1'b1);

        // push and pop in the same cycle, then a stall
        send(1'b0, 8'h33, 1'b0, 1'b1);
        send(1'b0, 8'h55, 1'b1, 1'b1);
        idle(3, 1'b0, 1'b1);
        idle(2, 1'b1, 1'b1);

        rand_run(1500);

        // mid-stream reset with FIFO0 full and FIFO1 holding one word
        idle(3, 1'b1, 1'b1);
        send(1'b0, 8'hC0, 1'b0, 1'b0);
        send(1'b0, 8'hC1, 1'b0, 1'b0);
        send(1'b1, 8'hD0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle(3, 1'b1, 1'b1);
        rand_run(500);

        // counter wrap
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 257; i++) send(1'b1, WIDTH'(i), 1'b0, 1'b1);
        idle(3, 1'b0, 1'b1);
        chk("wrap_count1", 32'(out1_count), 32'd1);
        chk("wrap_count0", 32'(out0_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
